// File: rtl/alu_exec_stage.sv
// Two-stage MIPS execute stage: decode/operand-select register (S1) feeding a
// combinational ALU, then a result register (S2) carrying flags and exception
// status. Valid/ready handshake on both sides.

package alu_exec_pkg;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

endpackage

// Combinational ALU. Shift amount is porta[4:0]; over is only meaningful for
// ADD/SUB and reads 0 for every other operation.
module alu_exec_alu
   import alu_exec_pkg::*;
#(
   parameter int DW = 32
) (
   input  alu_op_e         aluop_i,
   input  logic [DW-1:0]   porta_i,
   input  logic [DW-1:0]   portb_i,
   output logic [DW-1:0]   outport_o,
   output logic            zero_o,
   output logic            neg_o,
   output logic            over_o
);

   // Operation select plus signed-overflow detection.
   always_comb begin
      // NOTE: every combinationally driven signal gets a default first, so no branch can leave a latch behind.
      outport_o = '0;
      over_o    = 1'b0;
      case (aluop_i)
         ALU_SLL:  outport_o = portb_i << porta_i[4:0];
         ALU_SRL:  outport_o = portb_i >> porta_i[4:0];
         ALU_ADD: begin
            outport_o = porta_i + portb_i;
            over_o    = (porta_i[DW-1] == portb_i[DW-1]) && (outport_o[DW-1] != porta_i[DW-1]);
         end
         ALU_SUB: begin
            outport_o = porta_i - portb_i;
            over_o    = (porta_i[DW-1] != portb_i[DW-1]) && (outport_o[DW-1] != porta_i[DW-1]);
         end
         ALU_AND:  outport_o = porta_i & portb_i;
         ALU_OR:   outport_o = porta_i | portb_i;
         ALU_XOR:  outport_o = porta_i ^ portb_i;
         ALU_NOR:  outport_o = ~(porta_i | portb_i);
         ALU_SLT:  outport_o = {{(DW-1){1'b0}}, ($signed(porta_i) < $signed(portb_i))};
         ALU_SLTU: outport_o = {{(DW-1){1'b0}}, (porta_i < portb_i)};
         default:  outport_o = '0;
      endcase
      zero_o = (outport_o == '0);
      neg_o  = outport_o[DW-1];
   end

endmodule

module alu_exec_stage
   import alu_exec_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_instr,
   input  logic [DW-1:0]   in_rs_data,
   input  logic [DW-1:0]   in_rt_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_result,
   output logic [RW-1:0]   out_wsel,
   output logic            out_wen,
   output logic            out_zero,
   output logic            out_neg,
   output logic            out_ovf_exc,
   output logic            out_illegal
);

   // Instruction fields.
   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic [4:0]    shamt;
   logic [RW-1:0] rt_sel;
   logic [RW-1:0] rd_sel;
   logic [15:0]   imm;
   logic [DW-1:0] imm_sext;
   logic [DW-1:0] imm_zext;
   logic          unused_rs_field;

   assign opcode   = in_instr[31:26];
   assign rt_sel   = in_instr[20:16];
   assign rd_sel   = in_instr[15:11];
   assign shamt    = in_instr[10:6];
   assign funct    = in_instr[5:0];
   assign imm      = in_instr[15:0];
   assign imm_sext = {{(DW-16){imm[15]}}, imm};
   assign imm_zext = {{(DW-16){1'b0}}, imm};
   // The rs value arrives pre-read on in_rs_data; the select field itself is not needed here.
   assign unused_rs_field = ^in_instr[25:21];

   // Decoder outputs.
   alu_op_e       dec_aluop;
   logic [DW-1:0] dec_porta;
   logic [DW-1:0] dec_portb;
   logic [RW-1:0] dec_wsel;
   logic          dec_trap;
   logic          dec_illegal;

   // S1 (decode) and S2 (result) state.
   logic          s1_valid_q,   s1_valid_d;
   alu_op_e       s1_aluop_q,   s1_aluop_d;
   logic [DW-1:0] s1_porta_q,   s1_porta_d;
   logic [DW-1:0] s1_portb_q,   s1_portb_d;
   logic [RW-1:0] s1_wsel_q,    s1_wsel_d;
   logic          s1_trap_q,    s1_trap_d;
   logic          s1_illegal_q, s1_illegal_d;

   logic          s2_valid_q,   s2_valid_d;
   logic [DW-1:0] s2_result_q,  s2_result_d;
   logic [RW-1:0] s2_wsel_q,    s2_wsel_d;
   logic          s2_wen_q,     s2_wen_d;
   logic          s2_zero_q,    s2_zero_d;
   logic          s2_neg_q,     s2_neg_d;
   logic          s2_ovf_q,     s2_ovf_d;
   logic          s2_illegal_q, s2_illegal_d;

   // Handshake.
   logic          s2_adv;
   logic          s1_load;
   logic          accept;

   // ALU interface.
   logic [DW-1:0] alu_outport;
   logic          alu_zero;
   logic          alu_neg;
   logic          alu_over;
   logic          ovf_exc;

   // Instruction decode and operand selection.
   always_comb begin
      dec_aluop   = ALU_ADD;
      dec_porta   = in_rs_data;
      dec_portb   = in_rt_data;
      dec_wsel    = rt_sel;
      dec_trap    = 1'b0;
      dec_illegal = 1'b0;
      case (opcode)
         6'h00: begin
            dec_wsel = rd_sel;
            case (funct)
               6'h00: begin
                  dec_aluop = ALU_SLL;
                  dec_porta = {{(DW-5){1'b0}}, shamt};
               end
               6'h02: begin
                  dec_aluop = ALU_SRL;
                  dec_porta = {{(DW-5){1'b0}}, shamt};
               end
               6'h20: begin dec_aluop = ALU_ADD; dec_trap = 1'b1; end
               6'h21:       dec_aluop = ALU_ADD;
               6'h22: begin dec_aluop = ALU_SUB; dec_trap = 1'b1; end
               6'h23:       dec_aluop = ALU_SUB;
               6'h24:       dec_aluop = ALU_AND;
               6'h25:       dec_aluop = ALU_OR;
               6'h26:       dec_aluop = ALU_XOR;
               6'h27:       dec_aluop = ALU_NOR;
               6'h2A:       dec_aluop = ALU_SLT;
               6'h2B:       dec_aluop = ALU_SLTU;
               default:     dec_illegal = 1'b1;
            endcase
         end
         6'h08: begin dec_aluop = ALU_ADD;  dec_portb = imm_sext; dec_trap = 1'b1; end
         6'h09: begin dec_aluop = ALU_ADD;  dec_portb = imm_sext; end
         6'h0A: begin dec_aluop = ALU_SLT;  dec_portb = imm_sext; end
         6'h0B: begin dec_aluop = ALU_SLTU; dec_portb = imm_sext; end
         6'h0C: begin dec_aluop = ALU_AND;  dec_portb = imm_zext; end
         6'h0D: begin dec_aluop = ALU_OR;   dec_portb = imm_zext; end
         6'h0E: begin dec_aluop = ALU_XOR;  dec_portb = imm_zext; end
         6'h0F: begin
            // LUI is a left shift of the immediate by 16.
            dec_aluop = ALU_SLL;
            dec_porta = {{(DW-5){1'b0}}, 5'd16};
            dec_portb = imm_zext;
         end
         default: dec_illegal = 1'b1;
      endcase
      // Unsupported encodings become a harmless 0 + 0 with no destination.
      if (dec_illegal) begin
         dec_aluop = ALU_ADD;
         dec_porta = '0;
         dec_portb = '0;
         dec_wsel  = '0;
         dec_trap  = 1'b0;
      end
   end

   // Handshake: ready never depends on in_valid; flush and reset hold it low
   // so that an offered entry is never seen as transferred when it is dropped.
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_load  = !s1_valid_q || s2_adv;
   assign in_ready = s1_load && !flush && !RST;
   assign accept   = in_valid && in_ready;

   alu_exec_alu #(.DW(DW)) u_alu (
      .aluop_i   (s1_aluop_q),
      .porta_i   (s1_porta_q),
      .portb_i   (s1_portb_q),
      .outport_o (alu_outport),
      .zero_o    (alu_zero),
      .neg_o     (alu_neg),
      .over_o    (alu_over)
   );

   assign ovf_exc = s1_trap_q && alu_over;

   // Next-state for both pipeline registers, flush overriding the valids.
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_aluop_d   = s1_aluop_q;
      s1_porta_d   = s1_porta_q;
      s1_portb_d   = s1_portb_q;
      s1_wsel_d    = s1_wsel_q;
      s1_trap_d    = s1_trap_q;
      s1_illegal_d = s1_illegal_q;

      s2_valid_d   = s2_valid_q;
      s2_result_d  = s2_result_q;
      s2_wsel_d    = s2_wsel_q;
      s2_wen_d     = s2_wen_q;
      s2_zero_d    = s2_zero_q;
      s2_neg_d     = s2_neg_q;
      s2_ovf_d     = s2_ovf_q;
      s2_illegal_d = s2_illegal_q;

      if (s1_load) begin
         s1_valid_d = accept;
         if (accept) begin
            s1_aluop_d   = dec_aluop;
            s1_porta_d   = dec_porta;
            s1_portb_d   = dec_portb;
            s1_wsel_d    = dec_wsel;
            s1_trap_d    = dec_trap;
            s1_illegal_d = dec_illegal;
         end
      end

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         // Data only moves with a real entry, keeping outputs quiet otherwise.
         if (s1_valid_q) begin
            s2_result_d  = alu_outport;
            s2_wsel_d    = s1_wsel_q;
            s2_wen_d     = !s1_illegal_q && !ovf_exc && (s1_wsel_q != '0);
            s2_zero_d    = alu_zero;
            s2_neg_d     = alu_neg;
            s2_ovf_d     = ovf_exc;
            s2_illegal_d = s1_illegal_q;
         end
      end

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   // Pipeline registers with synchronous reset.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) begin
         // NOTE: datapath registers are reset as well, because outputs must read 0 while in reset.
         s1_valid_q   <= 1'b0;
         s1_aluop_q   <= ALU_SLL;
         s1_porta_q   <= '0;
         s1_portb_q   <= '0;
         s1_wsel_q    <= '0;
         s1_trap_q    <= 1'b0;
         s1_illegal_q <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_result_q  <= '0;
         s2_wsel_q    <= '0;
         s2_wen_q     <= 1'b0;
         s2_zero_q    <= 1'b0;
         s2_neg_q     <= 1'b0;
         s2_ovf_q     <= 1'b0;
         s2_illegal_q <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_aluop_q   <= s1_aluop_d;
         s1_porta_q   <= s1_porta_d;
         s1_portb_q   <= s1_portb_d;
         s1_wsel_q    <= s1_wsel_d;
         s1_trap_q    <= s1_trap_d;
         s1_illegal_q <= s1_illegal_d;
         s2_valid_q   <= s2_valid_d;
         s2_result_q  <= s2_result_d;
         s2_wsel_q    <= s2_wsel_d;
         s2_wen_q     <= s2_wen_d;
         s2_zero_q    <= s2_zero_d;
         s2_neg_q     <= s2_neg_d;
         s2_ovf_q     <= s2_ovf_d;
         s2_illegal_q <= s2_illegal_d;
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_result  = s2_result_q;
   assign out_wsel    = s2_wsel_q;
   assign out_wen     = s2_wen_q;
   assign out_zero    = s2_zero_q;
   assign out_neg     = s2_neg_q;
   assign out_ovf_exc = s2_ovf_q;
   assign out_illegal = s2_illegal_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: single-instruction vectors with
// hand-computed results, a backpressure stream, flush and mid-run reset.

module tb_alu_exec_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs_data;
   logic [31:0] in_rt_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_wsel;
   logic        out_wen;
   logic        out_zero;
   logic        out_neg;
   logic        out_ovf_exc;
   logic        out_illegal;

   int n_checks = 0;
   int n_fail   = 0;

   // Backpressure bookkeeping.
   logic [31:0] bp_exp [4];
   int          bp_sent;
   int          bp_recv;
   int          bp_cyc;
   logic        bp_stalled;
   logic        bp_saw_block;
   logic [31:0] bp_held_res;
   logic [4:0]  bp_held_wsel;
   int          flush_outs;

   always #5 CLK = ~CLK;

   alu_exec_stage dut (
      .CLK         (CLK),
      .RST         (RST),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_rs_data  (in_rs_data),
      .in_rt_data  (in_rt_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_wsel    (out_wsel),
      .out_wen     (out_wen),
      .out_zero    (out_zero),
      .out_neg     (out_neg),
      .out_ovf_exc (out_ovf_exc),
      .out_illegal (out_illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] r_instr(input logic [5:0] funct, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] shamt);
      return {6'h00, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // One instruction through an idle pipe: ready, 2-cycle latency, all result fields.
   task automatic run_single(input string tag, input logic [31:0] instr,
                             input logic [31:0] rs_d, input logic [31:0] rt_d,
                             input logic [31:0] exp_res, input logic [4:0] exp_wsel,
                             input logic exp_wen, input logic exp_zero, input logic exp_neg,
                             input logic exp_ovf, input logic exp_ill);
      @(posedge CLK); #1;
      in_valid   = 1'b1;
      in_instr   = instr;
      in_rs_data = rs_d;
      in_rt_data = rt_d;
      out_ready  = 1'b1;
      @(negedge CLK);
      check({tag, ".in_ready"}, in_ready, 1);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      @(negedge CLK);
      check({tag, ".valid_lat1"}, out_valid, 0);
      @(negedge CLK);
      check({tag, ".valid_lat2"}, out_valid, 1);
      check({tag, ".result"},     out_result, exp_res);
      check({tag, ".wsel"},       out_wsel, exp_wsel);
      check({tag, ".wen"},        out_wen, exp_wen);
      check({tag, ".zero"},       out_zero, exp_zero);
      check({tag, ".neg"},        out_neg, exp_neg);
      check({tag, ".ovf_exc"},    out_ovf_exc, exp_ovf);
      check({tag, ".illegal"},    out_illegal, exp_ill);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RST        = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      in_instr   = '0;
      in_rs_data = '0;
      in_rt_data = '0;
      out_ready  = 1'b0;

      // Reset state.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("reset.in_ready",  in_ready, 0);
      check("reset.out_valid", out_valid, 0);
      check("reset.result",    out_result, 0);
      check("reset.wen",       out_wen, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("reset.ready_after", in_ready, 1);

      //          tag      instr                                    rs            rt            result        wsel  wen zero neg ovf ill
      run_single("add",    r_instr(6'h20, 5'd1, 5'd2, 5'd3, 5'd0),  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'd3,  0, 0, 1, 1, 0);
      run_single("addu",   r_instr(6'h21, 5'd1, 5'd2, 5'd4, 5'd0),  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'd4,  1, 0, 1, 0, 0);
      run_single("lui",    i_instr(6'h0F, 5'd0, 5'd9, 16'h1234),    32'hDEADBEEF, 32'h00000000, 32'h12340000, 5'd9,  1, 0, 0, 0, 0);
      run_single("slti",   i_instr(6'h0A, 5'd1, 5'd5, 16'h0001),    32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5'd5,  1, 0, 0, 0, 0);
      run_single("sltiu",  i_instr(6'h0B, 5'd1, 5'd6, 16'h0001),    32'hFFFFFFFF, 32'h00000000, 32'h00000000, 5'd6,  1, 1, 0, 0, 0);
      run_single("sub_r0", r_instr(6'h22, 5'd1, 5'd2, 5'd0, 5'd0),  32'h00000005, 32'h00000003, 32'h00000002, 5'd0,  0, 0, 0, 0, 0);
      run_single("sub_ov", r_instr(6'h22, 5'd1, 5'd2, 5'd8, 5'd0),  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'd8,  0, 0, 0, 1, 0);
      run_single("sll",    r_instr(6'h00, 5'd0, 5'd2, 5'd7, 5'd4),  32'hFFFFFFFF, 32'h0000000F, 32'h000000F0, 5'd7,  1, 0, 0, 0, 0);
      run_single("addi",   i_instr(6'h08, 5'd1, 5'd11, 16'hFFFF),   32'h00000010, 32'h00000000, 32'h0000000F, 5'd11, 1, 0, 0, 0, 0);
      run_single("andi",   i_instr(6'h0C, 5'd1, 5'd12, 16'h8001),   32'hFFFFFFFF, 32'h00000000, 32'h00008001, 5'd12, 1, 0, 0, 0, 0);
      run_single("nor",    r_instr(6'h27, 5'd1, 5'd2, 5'd13, 5'd0), 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 5'd13, 1, 0, 1, 0, 0);
      run_single("ill_op", {6'h3F, 26'h0123456},                    32'h11111111, 32'h22222222, 32'h00000000, 5'd0,  0, 1, 0, 0, 1);
      run_single("ill_fn", r_instr(6'h01, 5'd1, 5'd2, 5'd3, 5'd0),  32'h11111111, 32'h22222222, 32'h00000000, 5'd0,  0, 1, 0, 0, 1);

      // Backpressure: four ORs back-to-back, out_ready low for cycles 3..6.
      for (int i = 0; i < 4; i++) bp_exp[i] = (32'h100 << i) | (i + 1);
      bp_sent      = 0;
      bp_recv      = 0;
      bp_cyc       = 0;
      bp_stalled   = 1'b0;
      bp_saw_block = 1'b0;
      bp_held_res  = '0;
      bp_held_wsel = '0;
      while (bp_recv < 4 && bp_cyc < 40) begin
         @(posedge CLK); #1;
         out_ready = !(bp_cyc >= 3 && bp_cyc <= 6);
         in_valid  = (bp_sent < 4);
         if (bp_sent < 4) begin
            in_instr   = r_instr(6'h25, 5'd1, 5'd2, 5'(10 + bp_sent), 5'd0);
            in_rs_data = 32'h100 << bp_sent;
            in_rt_data = 32'(bp_sent + 1);
         end
         @(negedge CLK);
         // Two entries in flight means both stages are full.
         check("bp.in_ready", in_ready, ((bp_sent - bp_recv) < 2) || out_ready);
         if (bp_stalled) begin
            check("bp.hold_valid",  out_valid, 1);
            check("bp.hold_result", out_result, bp_held_res);
            check("bp.hold_wsel",   out_wsel, bp_held_wsel);
         end
         if (out_valid && out_ready) begin
            check("bp.order_result", out_result, bp_exp[bp_recv]);
            check("bp.order_wsel",   out_wsel, 5'(10 + bp_recv));
            bp_recv++;
         end
         bp_stalled   = out_valid && !out_ready;
         bp_held_res  = out_result;
         bp_held_wsel = out_wsel;
         if (!in_ready) bp_saw_block = 1'b1;
         if (in_valid && in_ready) bp_sent++;
         bp_cyc++;
      end
      check("bp.all_received",  bp_recv, 4);
      check("bp.ready_dropped", bp_saw_block, 1);
      @(posedge CLK); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         check("bp.no_duplicate", out_valid, 0);
      end

      // Flush with two entries in flight and a new input offered.
      @(posedge CLK); #1;
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_instr   = r_instr(6'h21, 5'd1, 5'd2, 5'd3, 5'd0);
      in_rs_data = 32'd1;
      in_rt_data = 32'd1;
      @(posedge CLK); #1;
      in_rs_data = 32'd2;
      @(posedge CLK); #1;
      flush      = 1'b1;
      in_rs_data = 32'd3;
      @(negedge CLK);
      check("flush.pre_valid", out_valid, 1);
      @(posedge CLK); #1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge CLK);
      check("flush.out_valid", out_valid, 0);
      flush_outs = 0;
      repeat (4) begin
         @(negedge CLK);
         if (out_valid) flush_outs++;
      end
      check("flush.nothing_emerges", flush_outs, 0);
      run_single("post_flush", r_instr(6'h26, 5'd1, 5'd2, 5'd14, 5'd0), 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 5'd14, 1, 0, 0, 0, 0);

      // Reset mid-operation with an entry held in S2.
      @(posedge CLK); #1;
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_instr   = r_instr(6'h21, 5'd1, 5'd2, 5'd4, 5'd0);
      in_rs_data = 32'd1;
      in_rt_data = 32'd2;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("rst_mid.pre_valid",  out_valid, 1);
      check("rst_mid.pre_result", out_result, 32'd3);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      check("rst_mid.in_ready", in_ready, 0);
      @(negedge CLK);
      check("rst_mid.out_valid", out_valid, 0);
      check("rst_mid.result",    out_result, 0);
      check("rst_mid.wsel",      out_wsel, 0);
      check("rst_mid.wen",       out_wen, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("rst_mid.ready_after", in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Two-stage execute pipeline for the single-issue MIPS datapath.
- Decodes the instruction word and selects operands. Drives the existing combinational ALU through alu_if, using ALUOP, porta, portb and the returned outport/zero/neg/over.
- Registers results with flags and exception status.
- Valid/ready handshake on both sides. Sits between the register-read stage and writeback.

Parameters:
- DW, 32, datapath width; fixed at 32 for the MIPS ISA.
- RW, 5, register-select width.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous active-high reset.
- flush  in  1  drops all in-flight entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_rs_data  in  32  rs register value.
- in_rt_data  in  32  rt register value.
- out_valid  out  1  result entry present.
- out_ready  in  1  downstream accepts.
- out_result  out  32  ALU result.
- out_wsel  out  5  destination register.
- out_wen  out  1  register write permitted.
- out_zero  out  1  result == 0.
- out_neg  out  1  result[31].
- out_ovf_exc  out  1  signed overflow on a trapping op.
- out_illegal  out  1  unsupported opcode/funct.

Behaviour:
- Reset: s1_valid=0, s2_valid=0. All outputs 0, including in_ready. in_ready becomes 1 in the first cycle after RST deasserts.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - s2 advance condition: s2_adv = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_adv (combinational from out_ready; no combinational path from in_valid).
- S1 (decode register): on accept, capture ALUOP, porta, portb, wsel, a trap-enable bit and an illegal bit.
  - R-type (opcode 0x00), by funct:
    - 0x00 SLL, 0x02 SRL: porta = {27'b0, shamt}, portb = rt.
    - 0x20 ADD (trap), 0x21 ADDU, 0x22 SUB (trap), 0x23 SUBU.
    - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU.
    - porta = rs and portb = rt except for the shifts.
    - wsel = rd.
  - I-type: porta = rs, wsel = rt.
    - 0x08 ADDI (trap), 0x09 ADDIU, 0x0A SLTI, 0x0B SLTIU: immediate sign-extended.
    - 0x0C ANDI, 0x0D ORI, 0x0E XORI: immediate zero-extended.
  - LUI 0x0F: ALU_SLL, porta = 16, portb = {16'b0, imm}.
  - Any other opcode/funct: illegal=1, ALUOP=ALU_ADD, operands 0.
- S2 (result register): when s2_adv, load s1 contents plus the ALU outputs; s2_valid <= s1_valid.
  - out_ovf_exc = trap & over.
  - out_wen = !illegal & !out_ovf_exc & (wsel != 0).
  - Non-trap ops ignore over.
  - zero and neg come from the ALU.
- s1 update: when s2_adv (or s1 empty), s1_valid <= in accept.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- Stall: while out_valid & !out_ready, s2 holds all outputs stable. s1 fills, then in_ready=0. No loss, no duplication, order preserved.
- Flush: next edge s1_valid=0 and s2_valid=0. An in_valid in the same cycle is not accepted; flush has priority. Flush together with out_ready: the s2 entry counts as consumed only if out_valid & out_ready were both high that cycle.
- RST mid-operation: identical to flush, plus all output data cleared to 0.
- Widths: all arithmetic 32-bit. shamt is the ALU's porta[4:0]; upper porta bits are 0.

Test Plan:
- ADD: rs=0x7FFFFFFF, rt=0x00000001. Required: out_result=0x80000000, neg=1, ovf_exc=1, wen=0, out_valid 2 cycles after accept.
- ADDU with the same operands. Required: result=0x80000000, ovf_exc=0, wen=1, wsel=rd.
- LUI imm=0x1234, rt=9. Required: result=0x12340000, wsel=9, wen=1.
- SLTI rs=0xFFFFFFFF, imm=0x0001 → result=1. SLTIU rs=0xFFFFFFFF, imm=0x0001 → result=0, zero=1.
- Backpressure: stream 4 ORs back-to-back with out_ready=0 for cycles 3-6.
  - Required: in_ready low once s1 and s2 are both full.
  - Results emerge in order with no drop or duplicate.
  - Outputs stay stable while stalled.
- Flush with 2 entries in flight and in_valid=1. Required: out_valid=0 next cycle, that input not accepted. Also: SUB writing $0 gives wen=0; opcode 0x3F gives illegal=1, wen=0.
